// File: rtl/sap_pkg.sv
// Shared definitions for the SAP program counter: command encoding,
// default widths and the idle value driven onto the W bus.
package sap_pkg;

  // Decoded per-cycle command, one per clock edge
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INC  = 3'd1,
    LOAD = 3'd2,
    CALL = 3'd3,
    RET  = 3'd4
  } pc_cmd_e;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_STACK_DEPTH = 4;
  localparam int unsigned MAX_ADDR_W      = 16;

  // Value seen on the W bus when the counter is not driving it
  localparam logic [MAX_ADDR_W-1:0] BUS_IDLE = 16'hFFFF;

endpackage : sap_pkg

// File: rtl/sap_pc_ret_stack.sv
// Return-address LIFO for the SAP program counter. Push has priority
// over pop; a push when full or a pop when empty leaves the stack as is.
// Storage is not reset: entries above the current level are never read.
module sap_pc_ret_stack #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1),
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1'b1);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0]  r_level;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == LVL_ZERO);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~i_push & ~o_empty;

  // Indices are clamped so they stay inside the array even when unused
  assign w_wr_idx  = o_full  ? IDX_ZERO : IDX_W'(r_level);
  assign w_rd_idx  = o_empty ? IDX_ZERO : IDX_W'(r_level - LVL_ONE);

  assign o_data    = r_mem[w_rd_idx];
  assign o_level   = r_level;

  // Write the pushed return address into the next free slot
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  // Track occupancy; reset empties the stack without touching storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= LVL_ZERO;
    end else if (w_do_push) begin
      r_level <= r_level + LVL_ONE;
    end else if (w_do_pop) begin
      r_level <= r_level - LVL_ONE;
    end else begin
      r_level <= r_level;
    end
  end

endmodule : sap_pc_ret_stack

// File: rtl/sap_program_counter.sv
// SAP program counter with increment, jump and (optionally) call/return.
// Optional feature macro: SAP_PC_STACK_EN. When defined, Call/Ret use a
// return-address stack and report overflow/underflow through sticky flags;
// when undefined, Call/Ret are ignored and sp_level/ovf/unf read as zero.
// Command priority is Call > Ret > Lp > Cp (Lp > Cp without the stack).
module sap_program_counter
  import sap_pkg::*;
#(
  parameter  int unsigned           ADDR_W      = DEF_ADDR_W,
  parameter  int unsigned           STACK_DEPTH = DEF_STACK_DEPTH,
  parameter  logic [ADDR_W-1:0]     RST_ADDR    = {ADDR_W{1'b0}},
  localparam int unsigned           LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK_bar,
  input  logic              CLR_bar,
  input  logic              Cp,
  input  logic              Ep,
  input  logic              Lp,
  input  logic              Call,
  input  logic              Ret,
  input  logic [ADDR_W-1:0] W_bus_in,
  output logic [ADDR_W-1:0] W_bus_out,
  output logic [ADDR_W-1:0] count_q,
  output logic [LVL_W-1:0]  sp_level,
  output logic              ovf,
  output logic              unf
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

  pc_cmd_e           w_cmd;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_count_inc;
  logic [ADDR_W-1:0] w_count_nxt;

  assign w_count_inc = r_count + ADDR_ONE;
  assign count_q     = r_count;
  assign W_bus_out   = Ep ? r_count : BUS_IDLE[ADDR_W-1:0];

`ifdef SAP_PC_STACK_EN
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_stack_top;
  logic [LVL_W-1:0]  w_level;
  logic              r_ovf;
  logic              r_unf;

  // Single priority encoder: Call > Ret > Lp > Cp
  always_comb begin
    w_cmd = IDLE;
    if (Call) begin
      w_cmd = CALL;
    end else if (Ret) begin
      w_cmd = RET;
    end else if (Lp) begin
      w_cmd = LOAD;
    end else if (Cp) begin
      w_cmd = INC;
    end else begin
      w_cmd = IDLE;
    end
  end

  // The pushed return address is count+1, wrapping like Cp does
  sap_pc_ret_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .i_clk   (CLK_bar),
    .i_rst_n (CLR_bar),
    .i_push  (w_cmd == CALL),
    .i_pop   (w_cmd == RET),
    .i_data  (w_count_inc),
    .o_data  (w_stack_top),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky error flags: set on a rejected Call/Ret, cleared only by reset
  always_ff @(posedge CLK_bar or negedge CLR_bar) begin
    if (!CLR_bar) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | ((w_cmd == CALL) & w_full);
      r_unf <= r_unf | ((w_cmd == RET) & w_empty);
    end
  end

  assign sp_level = w_level;
  assign ovf      = r_ovf;
  assign unf      = r_unf;
`else
  logic w_unused;

  // Call and Ret exist on the port list but have no effect in this build
  assign w_unused = Call ^ Ret;

  // Priority encoder without the stack: Lp > Cp
  always_comb begin
    w_cmd = IDLE;
    if (Lp) begin
      w_cmd = LOAD;
    end else if (Cp) begin
      w_cmd = INC;
    end else begin
      w_cmd = IDLE;
    end
  end

  assign sp_level = {LVL_W{1'b0}};
  assign ovf      = 1'b0;
  assign unf      = 1'b0;
`endif

  // Next count from the decoded command; rejected Call/Ret hold the count
  always_comb begin
    w_count_nxt = r_count;
    case (w_cmd)
      INC:  w_count_nxt = w_count_inc;
      LOAD: w_count_nxt = W_bus_in;
`ifdef SAP_PC_STACK_EN
      CALL: begin
        if (!w_full) begin
          w_count_nxt = W_bus_in;
        end else begin
          w_count_nxt = r_count;
        end
      end
      RET: begin
        if (!w_empty) begin
          w_count_nxt = w_stack_top;
        end else begin
          w_count_nxt = r_count;
        end
      end
`endif
      default: w_count_nxt = r_count;
    endcase
  end

  // Count register; reset forces the start address immediately
  always_ff @(posedge CLK_bar or negedge CLR_bar) begin
    if (!CLR_bar) begin
      r_count <= RST_ADDR;
    end else begin
      r_count <= w_count_nxt;
    end
  end

endmodule : sap_program_counter

// File: tb/tb_sap_program_counter.sv
// Self-checking bench for sap_program_counter (ADDR_W=8, STACK_DEPTH=4,
// RST_ADDR=0). Stack scenarios apply when SAP_PC_STACK_EN is defined;
// otherwise the ignored-Call/Ret scenario runs instead.
module tb_sap_program_counter;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH + 1);
`ifdef SAP_PC_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic              CLK_bar;
  logic              CLR_bar;
  logic              Cp, Ep, Lp, Call, Ret;
  logic [ADDR_W-1:0] W_bus_in;
  logic [ADDR_W-1:0] W_bus_out;
  logic [ADDR_W-1:0] count_q;
  logic [LVL_W-1:0]  sp_level;
  logic              ovf, unf;

  int checks   = 0;
  int failures = 0;

  // Reference model: count as an integer, stack as a queue of return addresses
  int m_count;
  int m_stack[$];
  bit m_ovf, m_unf;

  sap_program_counter #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (DEPTH),
    .RST_ADDR    (8'h00)
  ) dut (
    .CLK_bar   (CLK_bar),
    .CLR_bar   (CLR_bar),
    .Cp        (Cp),
    .Ep        (Ep),
    .Lp        (Lp),
    .Call      (Call),
    .Ret       (Ret),
    .W_bus_in  (W_bus_in),
    .W_bus_out (W_bus_out),
    .count_q   (count_q),
    .sp_level  (sp_level),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial CLK_bar = 1'b0;
  always #5 CLK_bar = ~CLK_bar;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [ADDR_W+LVL_W+1:0] exp_state();
    return {ADDR_W'(m_count), LVL_W'(m_stack.size()), m_ovf, m_unf};
  endfunction

  function automatic logic [ADDR_W-1:0] exp_bus();
    return Ep ? ADDR_W'(m_count) : 8'hFF;
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Apply one clock edge's command to the model using the documented rules
  task automatic model_edge();
    if (STACK_EN && Call) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back((m_count + 1) % 256);
        m_count = W_bus_in;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (STACK_EN && Ret) begin
      if (m_stack.size() > 0) m_count = m_stack.pop_back();
      else m_unf = 1'b1;
    end else if (Lp) begin
      m_count = W_bus_in;
    end else if (Cp) begin
      m_count = (m_count + 1) % 256;
    end
  endtask

  // One rising edge; returns 1 time unit after it
  task automatic tick();
    @(posedge CLK_bar);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit c, input bit r, input bit l, input bit p, input logic [7:0] d);
    Call = c; Ret = r; Lp = l; Cp = p; W_bus_in = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    CLR_bar = 1'b0;
    model_reset();
    @(posedge CLK_bar);
    #2;
    CLR_bar = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A);
    Ep = 1'b1;
    tick();
    CLR_bar = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({count_q, sp_level, ovf, unf} !== exp_state()) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", {count_q, sp_level, ovf, unf}, exp_state());
    end
    checks++;
    if (W_bus_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_bus_ep1: got %h expected 00", W_bus_out);
    end
    Ep = 1'b0;
    #1;
    checks++;
    if (W_bus_out !== 8'hFF) begin
      failures++;
      $display("FAIL reset_bus_ep0: got %h expected FF", W_bus_out);
    end
    @(posedge CLK_bar);
    #1;
    checks++;
    if (count_q !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold_edge: got %h expected 00", count_q);
    end
    #1;
    CLR_bar = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_count_wrap();
    do_reset();
    Ep = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 257; i++) begin
      tick();
      checks++;
      if (count_q !== 8'(i % 256) || W_bus_out !== 8'(i % 256)) begin
        failures++;
        $display("FAIL count_wrap[%0d]: got count=%h bus=%h expected %h", i, count_q, W_bus_out, 8'(i % 256));
      end
    end
    Ep = 1'b0;
    #1;
    checks++;
    if (W_bus_out !== 8'hFF) begin
      failures++;
      $display("FAIL bus_idle: got %h expected FF", W_bus_out);
    end
  endtask

  task automatic test_load();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h10);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    tick();
    checks++;
    if (count_q !== 8'hA5) begin
      failures++;
      $display("FAIL load: got %h expected a5", count_q);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h10);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    tick();
    checks++;
    if (count_q !== 8'hA5) begin
      failures++;
      $display("FAIL load_over_inc: got %h expected a5", count_q);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h33);
    tick();
    checks++;
    if (count_q !== 8'hA5) begin
      failures++;
      $display("FAIL idle_hold: got %h expected a5", count_q);
    end
  endtask

`ifdef SAP_PC_STACK_EN
  task automatic test_call_ret();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h20);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
    tick();
    checks++;
    if (count_q !== 8'h80 || sp_level !== 3'd1) begin
      failures++;
      $display("FAIL call: got count=%h sp=%0d expected 80 sp=1", count_q, sp_level);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    tick();
    checks++;
    if (count_q !== 8'h21 || sp_level !== 3'd0) begin
      failures++;
      $display("FAIL ret: got count=%h sp=%0d expected 21 sp=0", count_q, sp_level);
    end
  endtask

  task automatic test_stack_limits();
    logic [7:0] tgt [5];
    logic [7:0] exp_ret [4];
    do_reset();
    for (int i = 0; i < 5; i++) tgt[i] = 8'($urandom_range(0, 255));
    exp_ret[0] = tgt[2] + 8'h01;
    exp_ret[1] = tgt[1] + 8'h01;
    exp_ret[2] = tgt[0] + 8'h01;
    exp_ret[3] = 8'h01;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, tgt[i]);
      tick();
    end
    checks++;
    if (count_q !== tgt[3] || sp_level !== 3'd4 || ovf !== 1'b1 || unf !== 1'b0) begin
      failures++;
      $display("FAIL overflow: got count=%h sp=%0d ovf=%b unf=%b expected %h 4 1 0",
               count_q, sp_level, ovf, unf, tgt[3]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      checks++;
      if (count_q !== exp_ret[i] || sp_level !== 3'(3 - i)) begin
        failures++;
        $display("FAIL pop[%0d]: got count=%h sp=%0d expected %h sp=%0d", i, count_q, sp_level, exp_ret[i], 3 - i);
      end
    end
    tick();
    checks++;
    if (count_q !== 8'h01 || sp_level !== 3'd0 || ovf !== 1'b1 || unf !== 1'b1) begin
      failures++;
      $display("FAIL underflow: got count=%h sp=%0d ovf=%b unf=%b expected 01 0 1 1", count_q, sp_level, ovf, unf);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
    tick();
    checks++;
    if (count_q !== 8'h77 || sp_level !== 3'd1 || ovf !== 1'b1 || unf !== 1'b1) begin
      failures++;
      $display("FAIL after_flags: got count=%h sp=%0d ovf=%b unf=%b expected 77 1 1 1", count_q, sp_level, ovf, unf);
    end
  endtask
`else
  task automatic test_call_ignored();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
    tick();
    checks++;
    if ({count_q, sp_level, ovf, unf} !== {8'h05, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL call_ignored: got %h expected count 05, zeros", {count_q, sp_level, ovf, unf});
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h44);
    tick();
    checks++;
    if ({count_q, sp_level, ovf, unf} !== {8'h06, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL call_plus_inc: got %h expected count 06, zeros", {count_q, sp_level, ovf, unf});
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if ({count_q, sp_level, ovf, unf} !== {8'h06, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL ret_ignored: got %h expected count 06, zeros", {count_q, sp_level, ovf, unf});
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
      tick();
    end
    #2;
    CLR_bar = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({count_q, sp_level, ovf, unf} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got %h expected all zero", {count_q, sp_level, ovf, unf});
    end
    #1;
    CLR_bar = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    checks++;
    if ({count_q, sp_level, ovf, unf} !== {8'h01, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL inc_after_reset: got %h expected count 01, zeros", {count_q, sp_level, ovf, unf});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
      Ep = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({count_q, sp_level, ovf, unf} !== exp_state() || W_bus_out !== exp_bus()) begin
        failures++;
        $display("FAIL random[%0d]: got state=%h bus=%h expected state=%h bus=%h",
                 n, {count_q, sp_level, ovf, unf}, W_bus_out, exp_state(), exp_bus());
      end
      if ($urandom_range(0, 60) == 0) begin
        #2;
        CLR_bar = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({count_q, sp_level, ovf, unf} !== exp_state()) begin
          failures++;
          $display("FAIL random_reset[%0d]: got %h expected %h", n, {count_q, sp_level, ovf, unf}, exp_state());
        end
        #1;
        CLR_bar = 1'b1;
      end
    end
  endtask

  initial begin
    CLR_bar = 1'b0;
    Ep = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    model_reset();
    #12;
    CLR_bar = 1'b1;
    test_reset();
    test_count_wrap();
    test_load();
`ifdef SAP_PC_STACK_EN
    test_call_ret();
    test_stack_limits();
`else
    test_call_ignored();
`endif
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sap_program_counter

// File: doc/sap_program_counter.md
SAP_PROGRAM_COUNTER -- requirements
Module: sap_program_counter

Interface
REQ-001 Parameter ADDR_W, default 8: counter and bus address width in bits (legal range 4..16).
REQ-002 Parameter STACK_DEPTH, default 4: return-address stack entries (legal range 1..16).
REQ-003 Parameter RST_ADDR, default 0: count value loaded on reset.
REQ-004 CLK_bar  input  1  sole clock; all state updates on its rising edge.
REQ-005 CLR_bar  input  1  reset; asynchronous assert, active-low.
REQ-006 Cp  input  1  increment count.
REQ-007 Ep  input  1  enable count onto W_bus_out.
REQ-008 Lp  input  1  load count from W_bus_in (jump).
REQ-009 Call  input  1  push count+1, then load W_bus_in.
REQ-010 Ret  input  1  pop top of stack into count.
REQ-011 W_bus_in  input  ADDR_W  jump/call target from W bus.
REQ-012 W_bus_out  output  ADDR_W  count when Ep=1, else all-ones bus idle value.
REQ-013 count_q  output  ADDR_W  registered count, always visible.
REQ-014 sp_level  output  $clog2(STACK_DEPTH+1)  stack occupancy, 0..STACK_DEPTH.
REQ-015 ovf  output  1  sticky: Call attempted with stack full.
REQ-016 unf  output  1  sticky: Ret attempted with stack empty.

Function
REQ-017 Per-cycle command priority SHALL be Call > Ret > Lp > Cp; lower-priority inputs asserted in the same cycle are ignored.
REQ-018 Cp alone: count <= count+1 modulo 2^ADDR_W; all-ones wraps to 0, no flag.
REQ-019 Lp: count <= W_bus_in next edge; stack untouched.
REQ-020 Call, sp_level<STACK_DEPTH: stack[sp_level] <= count+1 (modulo wrap), sp_level+1, count <= W_bus_in, all in one edge.
REQ-021 Call, sp_level==STACK_DEPTH: count, stack, sp_level unchanged; ovf <= 1.
REQ-022 Ret, sp_level>0: count <= stack[sp_level-1], sp_level-1, in one edge.
REQ-023 Ret, sp_level==0: count and sp_level unchanged; unf <= 1.
REQ-024 No command: all state holds.
REQ-025 W_bus_out SHALL be combinational from Ep and count_q (zero-cycle latency); count_q changes only on clock edges.
REQ-026 ovf/unf SHALL stay 1 until reset; they never block subsequent legal operations.

Reset
REQ-027 CLR_bar low SHALL immediately force count_q=RST_ADDR, sp_level=0, ovf=0, unf=0, independent of CLK_bar.
REQ-028 Stack storage contents need not be cleared; unreachable entries are don't-care.
REQ-029 Reset mid-operation wins over any command; first edge after CLR_bar deasserts executes that cycle's command normally.
REQ-030 W_bus_out during reset SHALL follow REQ-012 with count=RST_ADDR.

Configuration
REQ-031 Macro SAP_PC_STACK_EN defined: Call/Ret, stack, sp_level, ovf, unf implemented per REQ-020..023.
REQ-032 Macro undefined: no stack storage; Call and Ret ports remain but are ignored (priority becomes Lp > Cp); sp_level, ovf, unf tied to 0.

Structure
REQ-033 Shared package sap_pkg SHALL hold the pc_cmd_e enum (IDLE, INC, LOAD, CALL, RET), default-width localparams and the bus idle constant (all-ones).
REQ-034 Stack SHALL be a sub-module sap_pc_ret_stack (LIFO: push, pop, data, level, full, empty), instantiated only under SAP_PC_STACK_EN.
REQ-035 Command decode SHALL be a single priority encoder producing pc_cmd_e; no latches; no tri-state drivers.

Verification (ADDR_W=8, STACK_DEPTH=4, RST_ADDR=0, SAP_PC_STACK_EN defined unless stated)
REQ-036 Reset then Cp for 257 cycles, Ep=1 -> count_q 0..255, 0, 1; W_bus_out matches; Ep=0 -> W_bus_out=8'hFF.
REQ-037 count=8'h10, Lp=1, W_bus_in=8'hA5 -> count_q=8'hA5 next edge; Cp+Lp same cycle -> 8'hA5, not 8'h11.
REQ-038 count=8'h20, Call W_bus_in=8'h80; Ret -> count 8'h80, sp_level 1; then count 8'h21, sp_level 0.
REQ-039 Five Calls from empty -> sp_level 4, fifth leaves count at fourth target, ovf=1; five Rets -> four pops in LIFO order, fifth sets unf=1, count unchanged.
REQ-040 CLR_bar pulsed low between clock edges during Call sequence -> count_q=0, sp_level=0, flags 0 immediately; next Cp -> count 1.
REQ-041 SAP_PC_STACK_EN undefined: Call with W_bus_in=8'h44 at count 8'h05 -> count stays 8'h05; Call+Cp -> 8'h06; sp_level, ovf, unf remain 0.
